fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

- Instruction-fetch control stage that sits directly upstream of the 16-bit instruction register and the address register file.
- Drives the memory read using PC as the address and loads the instruction low byte, then the high byte, into the IR. Increments PC after each byte.
- Hands each completed 16-bit instruction to the decode/execute controller through a valid/ack handshake.
- A parameterised number of memory wait cycles per byte is supported.

## Interface

Parameters:
- MEM_WAIT, 0 — extra wait cycles before each byte load; legal range 0..15.
- CNT_W, 16 — width of the retired-fetch counter.

Ports:
- CLK  in  1  — single clock; all state changes on the rising edge.
- RESET_N  in  1  — asynchronous, active-low reset.
- Run  in  1  — level; while high, the sequencer fetches continuously.
- Stall  in  1  — level; freezes the sequencer in place.
- InstrAck  in  1  — decoder has consumed the current instruction.
- MemRd  out  1  — memory read strobe.
- ARF_OutBSel  out  2  — ARF output-B select; 2'b11 = PC (address bus).
- ARF_FunSel  out  2  — ARF function; 2'b11 = increment.
- ARF_RegSel  out  4  — ARF enables, active-low; bit0 = PC.
- IR_En  out  1  — IR load enable.
- IR_LH  out  1  — IR byte select; 0 = low byte, 1 = high byte.
- IR_FunSel  out  2  — IR function; 2'b01 = load.
- InstrValid  out  1  — IR holds a complete instruction.
- Busy  out  1  — high in any state other than IDLE.
- FetchCount  out  CNT_W  — number of instructions handed off; wraps.

## Operation

- States: IDLE, FETCH_LO, FETCH_HI, VALID.
- A 4-bit wait counter `wcnt` is cleared on every state entry.
- Outputs are Moore-decoded from the state plus `wcnt`. The state, `wcnt` and FetchCount are registered.
- Constant outputs: ARF_OutBSel = 2'b11, ARF_FunSel = 2'b11, IR_FunSel = 2'b01.

IDLE:
- MemRd=0, IR_En=0, ARF_RegSel=4'b1111, InstrValid=0.
- If Run=1 and Stall=0, go to FETCH_LO.

FETCH_LO:
- MemRd=1 and IR_LH=0.
- While `wcnt` < MEM_WAIT: increment `wcnt`; IR_En=0, ARF_RegSel=4'b1111.
- When `wcnt` == MEM_WAIT (the load cycle): IR_En=1 and ARF_RegSel=4'b1110, so the PC increments on the same edge. Go to FETCH_HI.

FETCH_HI:
- Identical to FETCH_LO but with IR_LH=1.
- The load cycle goes to VALID.

VALID:
- InstrValid=1, MemRd=0, IR_En=0, ARF_RegSel=4'b1111.
- On InstrAck=1: FetchCount increments (wraps modulo 2^CNT_W). Go to FETCH_LO if Run=1, otherwise IDLE.
- While InstrAck=0, stay in VALID regardless of Run.

Stall=1, in any state:
- State and `wcnt` hold.
- Forced: IR_En=0, ARF_RegSel=4'b1111, MemRd held at its state value.
- InstrAck is ignored, and FetchCount does not increment.
- Stall has priority over every transition.

Other rules:
- Run falling during FETCH_LO/FETCH_HI does not abort the fetch. The current instruction completes to VALID; the transition from VALID then goes to IDLE.
- InstrAck outside VALID has no effect.
- Reset (RESET_N=0, at any time including mid-fetch): immediately forces IDLE, `wcnt`=0, FetchCount=0.
  - Outputs at reset: MemRd=0, IR_En=0, IR_LH=0, ARF_RegSel=4'b1111, InstrValid=0, Busy=0.
  - A partially loaded IR is not cleared; that is the IR owner's concern.
- Enables never glitch active during reset: ARF_RegSel=4'b1111 and IR_En=0 are the reset-decode values.

## Timing

- Fetch latency:
  - From the edge leaving IDLE to InstrValid high: 2*(MEM_WAIT+1) cycles.
  - MEM_WAIT=0 gives 2 cycles.
- Back-to-back throughput: one instruction per 2*(MEM_WAIT+1)+1 cycles when InstrAck is high in the first VALID cycle.
- Loads complete on the rising edge that ends the load cycle:
  - IR and PC update on that edge.
  - InstrValid rises in the cycle after the high-byte edge.
- Each Stall cycle adds exactly one cycle of latency.
- Reset deassertion is synchronised by the system. The first Run sample is at the first rising edge after RESET_N goes high.

## Test plan

- Reset mid-fetch: MEM_WAIT=0, Run=1, RESET_N=0 during FETCH_HI -> same cycle: Busy=0, IR_En=0, ARF_RegSel=4'b1111, FetchCount=0.
- Single fetch: MEM_WAIT=0, Run pulsed for one cycle, memory returns 8'h3C then 8'hA5 -> IR=16'hA53C and PC+2 at cycle 2; InstrValid=1 from cycle 2 until InstrAck; FetchCount=1 after ack; returns to IDLE.
- Wait states: MEM_WAIT=3 -> IR_En pulses exactly at relative cycles 3 and 7; MemRd high for 8 cycles; InstrValid at cycle 8.
- Stall: MEM_WAIT=0, Stall=1 for 3 cycles starting in the FETCH_LO load cycle -> IR_En/PC enable suppressed for those 3 cycles; load happens in the cycle after Stall drops; InstrValid delayed by exactly 3 cycles; PC advanced exactly 2.
- Handshake hold: InstrAck low for 5 cycles in VALID with Run=1 -> InstrValid stays high, no memory reads, FetchCount unchanged; ack -> FETCH_LO next cycle, FetchCount+1.
- Counter wrap: CNT_W=4, 17 continuous fetches with immediate ack -> FetchCount reads 4'h1; PC advanced by 34 (mod 256).

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches a 16-bit instruction as two byte reads addressed by PC.
// It loads the low byte, then the high byte, into the IR, and increments PC after each byte.
// The completed instruction goes to the decode/execute controller over a valid/ack handshake.
// MEM_WAIT (0..15) adds extra wait cycles before each byte load.
module fetch_sequencer #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             Run,
  input  logic             Stall,
  input  logic             InstrAck,
  output logic             MemRd,
  output logic [1:0]       ARF_OutBSel,
  output logic [1:0]       ARF_FunSel,
  output logic [3:0]       ARF_RegSel,
  output logic             IR_En,
  output logic             IR_LH,
  output logic [1:0]       IR_FunSel,
  output logic             InstrValid,
  output logic             Busy,
  output logic [CNT_W-1:0] FetchCount
);

  localparam int unsigned WCNT_W = 4;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_WAIT);

  localparam logic [1:0] OUTB_PC  = 2'b11;
  localparam logic [1:0] ARF_INC  = 2'b11;
  localparam logic [1:0] IR_LOAD  = 2'b01;
  localparam logic [3:0] REGS_OFF = 4'b1111;
  localparam logic [3:0] REGS_PC  = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH_LO = 2'd1,
    S_FETCH_HI = 2'd2,
    S_VALID    = 2'd3
  } state_t;

  state_t             r_state;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [CNT_W-1:0]   r_fetch_count;

  logic w_fetching;
  logic w_last_wait;
  logic w_load;

  assign w_fetching  = (r_state == S_FETCH_LO) || (r_state == S_FETCH_HI);
  assign w_last_wait = (r_wcnt == WAIT_LAST);
  // A byte is loaded only in the final wait cycle and only when not stalled.
  assign w_load      = w_fetching && w_last_wait && !Stall;

  // State, wait counter and retired-fetch counter; Stall freezes everything.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= S_IDLE;
      r_wcnt        <= '0;
      r_fetch_count <= '0;
    end else if (!Stall) begin
      case (r_state)
        S_IDLE: begin
          if (Run) begin
            r_state <= S_FETCH_LO;
            r_wcnt  <= '0;
          end
        end
        S_FETCH_LO: begin
          if (w_last_wait) begin
            r_state <= S_FETCH_HI;
            r_wcnt  <= '0;
          end else begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
          end
        end
        S_FETCH_HI: begin
          if (w_last_wait) begin
            r_state <= S_VALID;
            r_wcnt  <= '0;
          end else begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
          end
        end
        S_VALID: begin
          if (InstrAck) begin
            r_fetch_count <= r_fetch_count + CNT_W'(1);
            r_state       <= Run ? S_FETCH_LO : S_IDLE;
            r_wcnt        <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wcnt  <= '0;
        end
      endcase
    end
  end

  // Moore decode from the registered state; Stall only masks the load enables.
  always_comb begin
    ARF_OutBSel = OUTB_PC;
    ARF_FunSel  = ARF_INC;
    IR_FunSel   = IR_LOAD;
    MemRd       = w_fetching;
    IR_En       = w_load;
    IR_LH       = (r_state == S_FETCH_HI);
    ARF_RegSel  = w_load ? REGS_PC : REGS_OFF;
    InstrValid  = (r_state == S_VALID);
    Busy        = (r_state != S_IDLE);
    FetchCount  = r_fetch_count;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (MEM_WAIT=0/CNT_W=4 and MEM_WAIT=3/CNT_W=16)
// share stimulus; a fetch-progress reference model plus emulated PC/IR/memory check every cycle.
module tb_fetch_sequencer;

  localparam int NDUT = 2;

  logic clk = 1'b0;
  logic rst_n, run, stall, ack;

  logic       memrd  [NDUT];
  logic [1:0] outbsel[NDUT];
  logic [1:0] funsel [NDUT];
  logic [3:0] regsel [NDUT];
  logic       iren   [NDUT];
  logic       irlh   [NDUT];
  logic [1:0] irfun  [NDUT];
  logic       ivalid [NDUT];
  logic       busy   [NDUT];
  logic [3:0]  fc0;
  logic [15:0] fc1;

  always #5 clk = ~clk;

  fetch_sequencer #(.MEM_WAIT(0), .CNT_W(4)) dut0 (
    .CLK(clk), .RESET_N(rst_n), .Run(run), .Stall(stall), .InstrAck(ack),
    .MemRd(memrd[0]), .ARF_OutBSel(outbsel[0]), .ARF_FunSel(funsel[0]),
    .ARF_RegSel(regsel[0]), .IR_En(iren[0]), .IR_LH(irlh[0]), .IR_FunSel(irfun[0]),
    .InstrValid(ivalid[0]), .Busy(busy[0]), .FetchCount(fc0)
  );

  fetch_sequencer #(.MEM_WAIT(3), .CNT_W(16)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .Run(run), .Stall(stall), .InstrAck(ack),
    .MemRd(memrd[1]), .ARF_OutBSel(outbsel[1]), .ARF_FunSel(funsel[1]),
    .ARF_RegSel(regsel[1]), .IR_En(iren[1]), .IR_LH(irlh[1]), .IR_FunSel(irfun[1]),
    .InstrValid(ivalid[1]), .Busy(busy[1]), .FetchCount(fc1)
  );

  // Memory image, reference model and emulated downstream registers.
  logic [7:0]  mem [256];
  int          m_mode[NDUT];   // 0 idle, 1 fetching, 2 instruction waiting for ack
  int          m_prog[NDUT];   // cycles of fetch work completed so far
  int          m_cnt [NDUT];
  logic [7:0]  m_pc  [NDUT];
  logic [15:0] m_ir  [NDUT];
  logic [7:0]  e_pc  [NDUT];
  logic [15:0] e_ir  [NDUT];
  logic        s_irld[NDUT];
  logic        s_lh  [NDUT];
  logic        s_pcinc[NDUT];

  int n_vec = 0;
  int n_err = 0;

  function automatic int wt(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic [15:0] cmask(input int k);
    return (k == 0) ? 16'h000F : 16'hFFFF;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d at %0t: got %0h want %0h", name, k, $time, act, exp);
    end
  endtask

  // Advance the model and the emulated PC/IR on each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NDUT; k++) begin
        m_mode[k] = 0;
        m_prog[k] = 0;
        m_cnt[k]  = 0;
      end
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        if (s_irld[k]) begin
          if (s_lh[k]) e_ir[k][15:8] = mem[e_pc[k]];
          else         e_ir[k][7:0]  = mem[e_pc[k]];
        end
        if (s_pcinc[k]) e_pc[k] = e_pc[k] + 8'd1;
        if (!stall) begin
          case (m_mode[k])
            0: if (run) begin
              m_mode[k] = 1;
              m_prog[k] = 0;
            end
            1: begin
              if (m_prog[k] % (wt(k) + 1) == wt(k)) begin
                if (m_prog[k] < wt(k) + 1) m_ir[k][7:0]  = mem[m_pc[k]];
                else                       m_ir[k][15:8] = mem[m_pc[k]];
                m_pc[k] = m_pc[k] + 8'd1;
              end
              m_prog[k]++;
              if (m_prog[k] == 2 * (wt(k) + 1)) m_mode[k] = 2;
            end
            default: if (ack) begin
              m_cnt[k]++;
              m_mode[k] = run ? 1 : 0;
              m_prog[k] = 0;
            end
          endcase
        end
      end
    end
  end

  // Compare every output of both instances against the model, then sample enables.
  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      int w;
      logic fet, ld, lh;
      logic [15:0] fc;
      w   = wt(k);
      fet = (m_mode[k] == 1);
      ld  = fet && (m_prog[k] % (w + 1) == w) && !stall;
      lh  = fet && (m_prog[k] >= w + 1);
      fc  = (k == 0) ? 16'(fc0) : fc1;
      chk("MemRd",       k, 32'(memrd[k]),   32'(fet));
      chk("IR_En",       k, 32'(iren[k]),    32'(ld));
      chk("ARF_RegSel",  k, 32'(regsel[k]),  32'({3'b111, ~ld}));
      chk("IR_LH",       k, 32'(irlh[k]),    32'(lh));
      chk("InstrValid",  k, 32'(ivalid[k]),  32'(m_mode[k] == 2));
      chk("Busy",        k, 32'(busy[k]),    32'(m_mode[k] != 0));
      chk("FetchCount",  k, 32'(fc),         32'(16'(m_cnt[k]) & cmask(k)));
      chk("ARF_OutBSel", k, 32'(outbsel[k]), 32'd3);
      chk("ARF_FunSel",  k, 32'(funsel[k]),  32'd3);
      chk("IR_FunSel",   k, 32'(irfun[k]),   32'd1);
      chk("PC",          k, 32'(e_pc[k]),    32'(m_pc[k]));
      chk("IR",          k, 32'(e_ir[k]),    32'(m_ir[k]));
      s_irld[k]  = iren[k] && (irfun[k] == 2'b01);
      s_lh[k]    = irlh[k];
      s_pcinc[k] = !regsel[k][0] && (funsel[k] == 2'b11);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic a, input logic rn);
    @(negedge clk);
    run   = r;
    stall = s;
    ack   = a;
    rst_n = rn;
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] pc_ref;
    logic r, s, a, rn;
    for (int k = 0; k < NDUT; k++) begin
      m_pc[k] = 8'd0; m_ir[k] = 16'd0; e_pc[k] = 8'd0; e_ir[k] = 16'd0;
      s_irld[k] = 1'b0; s_lh[k] = 1'b0; s_pcinc[k] = 1'b0;
    end
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h3C;
    mem[1] = 8'hA5;
    run = 1'b0; stall = 1'b0; ack = 1'b0;
    rst_n = 1'b0;

    // Reset state.
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_busy",   0, 32'(busy[0]),   32'd0);
    chk("rst_fc",     0, 32'(fc0),       32'd0);
    chk("rst_regsel", 0, 32'(regsel[0]), 32'hF);
    chk("rst_iren",   0, 32'(iren[0]),   32'd0);
    chk("rst_memrd",  0, 32'(memrd[0]),  32'd0);

    // Single fetch with a one-cycle Run pulse; dut1 shows the wait-state pattern.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("w3_iren",  1, 32'(iren[1]),   32'(i == 3 || i == 7));
      chk("w3_memrd", 1, 32'(memrd[1]),  32'(i < 8));
      chk("w3_valid", 1, 32'(ivalid[1]), 32'(i >= 8));
      if (i == 2) begin
        chk("sf_valid", 0, 32'(ivalid[0]), 32'd1);
        chk("sf_ir",    0, 32'(e_ir[0]),   32'h0000A53C);
        chk("sf_pc",    0, 32'(e_pc[0]),   32'd2);
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sf_fc0",  0, 32'(fc0),     32'd1);
    chk("sf_fc1",  1, 32'(fc1),     32'd1);
    chk("sf_idle", 0, 32'(busy[0]), 32'd0);
    chk("w3_ir",   1, 32'(e_ir[1]), 32'h0000A53C);
    chk("w3_pc",   1, 32'(e_pc[1]), 32'd2);

    // Handshake hold with Run high, then ack straight into a stalled low-byte load.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("hold_valid", 0, 32'(ivalid[0]), 32'd1);
      chk("hold_memrd", 0, 32'(memrd[0]),  32'd0);
      chk("hold_fc",    0, 32'(fc0),       32'd1);
    end
    step(1'b1, 1'b0, 1'b1, 1'b1);
    pc_ref = e_pc[0];
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk("stall_memrd", 0, 32'(memrd[0]),  32'd1);
      chk("stall_iren",  0, 32'(iren[0]),   32'd0);
      chk("stall_fc",    0, 32'(fc0),       32'd2);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_lo", 0, 32'({iren[0], irlh[0]}), 32'b10);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_hi", 0, 32'({iren[0], irlh[0]}), 32'b11);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_valid", 0, 32'(ivalid[0]), 32'd1);
    chk("stall_pc",    0, 32'(e_pc[0]),   32'(8'(pc_ref + 8'd2)));
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // Reset asserted where dut0 would be in its high-byte fetch.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_busy",   0, 32'(busy[0]),   32'd0);
    chk("mid_iren",   0, 32'(iren[0]),   32'd0);
    chk("mid_regsel", 0, 32'(regsel[0]), 32'hF);
    chk("mid_fc",     0, 32'(fc0),       32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Seventeen back-to-back fetches wrap the 4-bit counter.
    pc_ref = e_pc[0];
    for (int i = 0; i < 51; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_fc",   0, 32'(fc0),     32'd1);
    chk("wrap_pc",   0, 32'(e_pc[0]), 32'(8'(pc_ref + 8'd34)));
    chk("wrap_idle", 0, 32'(busy[0]), 32'd0);

    // Random traffic, including occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 9) < 7);
      s  = ($urandom_range(0, 9) < 2);
      a  = ($urandom_range(0, 9) < 4);
      rn = ($urandom_range(0, 199) != 0);
      step(r, s, a, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
